// File: rtl/seq_divider_pkg.sv
// Shared types, constants and two's-complement helpers for the sequential divider.
package seq_divider_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int MAX_WIDTH     = 32;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // Works on a zero-extended MAX_WIDTH value; the low WIDTH bits of the result
    // are the correct WIDTH-bit two's-complement negation.
    function automatic logic [MAX_WIDTH-1:0] cond_negate(input logic [MAX_WIDTH-1:0] x,
                                                         input logic               neg);
        return neg ? (~x + MAX_WIDTH'(1)) : x;
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/response bundle of the sequential divider.
interface seq_divider_if
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             m;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             busy;
    logic             done;
    logic             div0;
    logic             ov;

    modport master (
        output start, a, b, m,
        input  q, r, busy, done, div0, ov
    );

    modport slave (
        input  start, a, b, m,
        output q, r, busy, done, div0, ov
    );
endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial subtract, keep or restore.
module div_step
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q_bit
);
    // One extra bit: the shifted remainder can reach 2*|b|-1.
    logic [WIDTH:0] w_shift;

    assign w_shift = {i_rem, i_bit};
    assign o_q_bit = (w_shift >= {1'b0, i_dvs});
    assign o_rem   = o_q_bit ? WIDTH'(w_shift - {1'b0, i_dvs}) : w_shift[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, unsigned or signed mode.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave s_bus
);
    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_busy;
    logic             r_done;
    logic             r_div0;
    logic             r_ov;

    logic             w_load;
    logic             w_load_div0;
    logic             w_step;
    logic             w_finish;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_q_mag;
    logic             w_q_bit;

    assign w_a_neg = s_bus.m & s_bus.a[WIDTH-1];
    assign w_b_neg = s_bus.m & s_bus.b[WIDTH-1];

    // r_dvd doubles as the quotient register: dividend bits leave at the top
    // while quotient bits enter at the bottom.
    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem   (r_rem),
        .i_bit   (r_dvd[WIDTH-1]),
        .i_dvs   (r_dvs),
        .o_rem   (w_rem_next),
        .o_q_bit (w_q_bit)
    );

    assign w_q_mag = {r_dvd[WIDTH-2:0], w_q_bit};

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_load_div0  = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (s_bus.start) begin
                    if (|s_bus.b) begin
                        w_load       = 1'b1;
                        w_state_next = CALC;
                    end else begin
                        w_load_div0  = 1'b1;
                        w_state_next = DONE;
                    end
                end
            end
            CALC: begin
                w_step = 1'b1;
                if (r_cnt == LAST_CNT) begin
                    w_finish     = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_rem   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_div0  <= 1'b0;
            r_ov    <= 1'b0;
        end else begin
            r_done <= w_finish | w_load_div0;
            if (w_load) begin
                r_dvd   <= WIDTH'(cond_negate(MAX_WIDTH'(s_bus.a), w_a_neg));
                r_dvs   <= WIDTH'(cond_negate(MAX_WIDTH'(s_bus.b), w_b_neg));
                r_rem   <= '0;
                r_cnt   <= '0;
                r_q_neg <= w_a_neg ^ w_b_neg;
                r_r_neg <= w_a_neg;
                r_div0  <= 1'b0;
                r_ov    <= s_bus.m && (s_bus.a == MOST_NEG) && (s_bus.b == '1);
                r_busy  <= 1'b1;
            end else if (w_load_div0) begin
                r_q    <= '1;
                r_r    <= s_bus.a;
                r_div0 <= 1'b1;
                r_ov   <= 1'b0;
            end else if (w_step) begin
                r_dvd <= w_q_mag;
                r_rem <= w_rem_next;
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_finish) begin
                    // Magnitude of most-negative / 1 wraps back to most-negative: the overflow result.
                    r_q    <= WIDTH'(cond_negate(MAX_WIDTH'(w_q_mag), r_q_neg));
                    r_r    <= WIDTH'(cond_negate(MAX_WIDTH'(w_rem_next), r_r_neg));
                    r_busy <= 1'b0;
                end
            end
        end
    end

    assign s_bus.q    = r_q;
    assign s_bus.r    = r_r;
    assign s_bus.busy = r_busy;
    assign s_bus.done = r_done;
    assign s_bus.div0 = r_div0;
    assign s_bus.ov   = r_ov;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH=4): directed vectors, robustness cases and a full sweep.
module tb_seq_divider;

    typedef struct packed {
        logic [3:0] q;
        logic [3:0] r;
        logic       div0;
        logic       ov;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_push = 0;
    int   n_done = 0;
    exp_t sb_q[$];

    seq_divider_if #(.WIDTH(4)) bus ();

    seq_divider #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .s_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference using the language's own division, which truncates toward zero.
    function automatic exp_t model(input logic [3:0] ma, input logic [3:0] mb, input logic mm);
        exp_t e;
        int   na;
        int   nb;
        if (mb == 4'h0) begin
            e = '{q: 4'hF, r: ma, div0: 1'b1, ov: 1'b0};
        end else begin
            if (mm) begin
                na = int'($signed(ma));
                nb = int'($signed(mb));
            end else begin
                na = int'(ma);
                nb = int'(mb);
            end
            e.q    = 4'(na / nb);
            e.r    = 4'(na % nb);
            e.div0 = 1'b0;
            e.ov   = mm && (ma == 4'h8) && (mb == 4'hF);
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'(bus.done), 32'(0));
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                n_done++;
                check("q", 32'(bus.q), 32'(e.q));
                check("r", 32'(bus.r), 32'(e.r));
                check("div0", 32'(bus.div0), 32'(e.div0));
                check("ov", 32'(bus.ov), 32'(e.ov));
            end
        end
    end

    // Called at the first negedge after the start edge; counts cycles until done.
    task automatic wait_done(output int lat, output int busy_cnt, output bit seen);
        lat      = 0;
        busy_cnt = 0;
        seen     = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            if (k > 1) @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        check("done_seen", 32'(seen), 32'(1));
    endtask

    task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_, input logic tm, input exp_t e);
        int lat;
        int busy_cnt;
        bit seen;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_;
        bus.m     = tm;
        sb_q.push_back(e);
        n_push++;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = ~ta;
        bus.b     = ~tb_;
        bus.m     = ~tm;
        wait_done(lat, busy_cnt, seen);
        check("latency", 32'(lat), (tb_ == 4'h0) ? 32'(1) : 32'(5));
        check("busy_cycles", 32'(busy_cnt), (tb_ == 4'h0) ? 32'(0) : 32'(4));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        int  busy_cnt;
        bit  seen;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = 4'h0;
        bus.b     = 4'h0;
        bus.m     = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_q", 32'(bus.q), 32'(0));
        check("rst_r", 32'(bus.r), 32'(0));
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_done", 32'(bus.done), 32'(0));
        check("rst_div0", 32'(bus.div0), 32'(0));
        check("rst_ov", 32'(bus.ov), 32'(0));

        // Directed vectors, hand-computed.
        run_op(4'hD, 4'h5, 1'b0, '{q: 4'h2, r: 4'h3, div0: 1'b0, ov: 1'b0});
        run_op(4'h9, 4'h2, 1'b1, '{q: 4'hD, r: 4'hF, div0: 1'b0, ov: 1'b0});
        run_op(4'h5, 4'hC, 1'b1, '{q: 4'hF, r: 4'h1, div0: 1'b0, ov: 1'b0});
        run_op(4'h5, 4'h0, 1'b0, '{q: 4'hF, r: 4'h5, div0: 1'b1, ov: 1'b0});
        run_op(4'h5, 4'h0, 1'b1, '{q: 4'hF, r: 4'h5, div0: 1'b1, ov: 1'b0});
        run_op(4'h8, 4'hF, 1'b1, '{q: 4'h8, r: 4'h0, div0: 1'b0, ov: 1'b1});
        run_op(4'h8, 4'hF, 1'b0, '{q: 4'h0, r: 4'h8, div0: 1'b0, ov: 1'b0});

        // Start re-pulsed during CALC must be ignored.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 4'hD;
        bus.b     = 4'h5;
        bus.m     = 1'b0;
        sb_q.push_back('{q: 4'h2, r: 4'h3, div0: 1'b0, ov: 1'b0});
        n_push++;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 4'h7;
        bus.b     = 4'h2;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat, busy_cnt, seen);
        repeat (8) @(negedge clk);

        // Reset two cycles into an operation aborts it silently.
        bus.start = 1'b1;
        bus.a     = 4'hD;
        bus.b     = 4'h5;
        bus.m     = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_q", 32'(bus.q), 32'(0));
        check("abort_r", 32'(bus.r), 32'(0));
        check("abort_busy", 32'(bus.busy), 32'(0));
        check("abort_done", 32'(bus.done), 32'(0));
        check("abort_div0", 32'(bus.div0), 32'(0));
        check("abort_ov", 32'(bus.ov), 32'(0));
        repeat (8) @(negedge clk);
        run_op(4'hC, 4'h5, 1'b0, '{q: 4'h2, r: 4'h2, div0: 1'b0, ov: 1'b0});

        // Full sweep, back-to-back starts issued as soon as the block is idle.
        for (int mm = 0; mm < 2; mm++) begin
            for (int ia = 0; ia < 16; ia++) begin
                for (int ib = 0; ib < 16; ib++) begin
                    run_op(4'(ia), 4'(ib), 1'(mm), model(4'(ia), 4'(ib), 1'(mm)));
                end
            end
        end

        repeat (4) @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'(0));
        check("done_count", 32'(n_done), 32'(n_push));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
